// File: rtl/bcd_pkg.sv
// Shared BCD types, digit limits and the load clamp used by the scan counter.
package bcd_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  typedef logic [3:0] bcd_t;

  // Any nibble outside the decimal range is forced to 9 so the counter never
  // holds a non-BCD code.
  function automatic bcd_t bcd_clamp(input bcd_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the counter: nibble register with load, increment and
// decrement, plus carry/borrow links to the neighbouring digits.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  bcd_t load_val,
  input  logic carry_in,
  input  logic borrow_in,
  output bcd_t digit,
  output logic carry_out,
  output logic borrow_out
);

  // A digit passes the carry/borrow on only when it is itself wrapping, so the
  // whole chain ripples combinationally within one edge.
  always_comb begin
    carry_out  = carry_in  && (digit == BCD_MAX);
    borrow_out = borrow_in && (digit == BCD_MIN);
  end

  // Digit register: load has priority over counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit <= BCD_MIN;
    end else if (load) begin
      digit <= bcd_clamp(load_val);
    end else if (carry_in) begin
      digit <= (digit == BCD_MAX) ? BCD_MIN : digit + 4'd1;
    end else if (borrow_in) begin
      digit <= (digit == BCD_MIN) ? BCD_MAX : digit - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with a step prescaler and a time-multiplexed
// digit scanner feeding a BCD-to-7-segment decoder (W,X,Y,Z = bit3..bit0).
module bcd_scan_counter
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 2,
  parameter int PRESCALE   = 4,
  parameter int SCAN_DIV   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    up_dn,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic [3:0]              digit_bcd,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    wrap
);

  localparam int PSC_W = (PRESCALE   > 1) ? $clog2(PRESCALE)   : 1;
  localparam int DIV_W = (SCAN_DIV   > 1) ? $clog2(SCAN_DIV)   : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [PSC_W-1:0]  psc;
  logic [DIV_W-1:0]  scan_div;
  logic [IDX_W-1:0]  scan_idx;
  logic              step;
  logic [NUM_DIGITS:0] carry;
  logic [NUM_DIGITS:0] borrow;
  bcd_t              digits [NUM_DIGITS];

  // A step happens on the prescaler's terminal enabled cycle; load discards it.
  always_comb begin
    step      = en && (psc == PSC_W'(PRESCALE - 1)) && !load;
    carry[0]  = step && up_dn;
    borrow[0] = step && !up_dn;
  end

  // Prescaler: cleared by load, holds while disabled, wraps on each step edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc <= '0;
    end else if (load) begin
      psc <= '0;
    end else if (en) begin
      psc <= (psc == PSC_W'(PRESCALE - 1)) ? '0 : psc + PSC_W'(1);
    end
  end

  genvar k;
  generate
    for (k = 0; k < NUM_DIGITS; k++) begin : g_digit
      bcd_digit u_digit (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .load_val   (load_val[4*k +: 4]),
        .carry_in   (carry[k]),
        .borrow_in  (borrow[k]),
        .digit      (digits[k]),
        .carry_out  (carry[k+1]),
        .borrow_out (borrow[k+1])
      );
      assign count[4*k +: 4] = digits[k];
    end
  endgenerate

  // Roll-over pulse: a carry/borrow out of the top digit means every digit
  // wrapped; any other edge clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap <= 1'b0;
    end else begin
      wrap <= carry[NUM_DIGITS] || borrow[NUM_DIGITS];
    end
  end

  // Free-running scanner: dwell SCAN_DIV cycles per digit, select kept one-hot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_div  <= '0;
      scan_idx  <= '0;
      digit_sel <= NUM_DIGITS'(1);
    end else if (scan_div == DIV_W'(SCAN_DIV - 1)) begin
      scan_div <= '0;
      if (scan_idx == IDX_W'(NUM_DIGITS - 1)) begin
        scan_idx  <= '0;
        digit_sel <= NUM_DIGITS'(1);
      end else begin
        scan_idx  <= scan_idx + IDX_W'(1);
        digit_sel <= digit_sel << 1;
      end
    end else begin
      scan_div <= scan_div + DIV_W'(1);
    end
  end

  // Scanned nibble straight from the digit registers, so it tracks count with
  // no extra cycle of delay.
  always_comb begin
    digit_bcd = digits[scan_idx];
  end

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Self-checking bench for bcd_scan_counter: a decimal reference model pushes
// per-cycle expectations into a queue, popped and compared on the falling edge,
// plus directed checks of the scenarios of interest.
module tb_bcd_scan_counter;

  localparam int N        = 2;
  localparam int PRESCALE = 4;
  localparam int SCAN_DIV = 2;
  localparam int W        = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         up_dn;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic [3:0]   digit_bcd;
  logic [N-1:0] digit_sel;
  logic         wrap;

  always #5 clk = ~clk;

  bcd_scan_counter #(
    .NUM_DIGITS (N),
    .PRESCALE   (PRESCALE),
    .SCAN_DIV   (SCAN_DIV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .up_dn     (up_dn),
    .load      (load),
    .load_val  (load_val),
    .count     (count),
    .digit_bcd (digit_bcd),
    .digit_sel (digit_sel),
    .wrap      (wrap)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model, kept in plain decimal integers.
  typedef struct {
    logic [W-1:0] cnt;
    logic [N-1:0] sel;
    logic [3:0]   dig;
    logic         wrp;
  } exp_t;

  exp_t sb [$];
  int   m_val  = 0;
  int   m_psc  = 0;
  int   m_idx  = 0;
  int   m_div  = 0;
  bit   m_wrap = 0;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int t;
    t = v;
    r = '0;
    for (int i = 0; i < N; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int clamp_val(input logic [W-1:0] x);
    int v, mult, nib;
    v = 0;
    mult = 1;
    for (int i = 0; i < N; i++) begin
      nib = int'(x[4*i +: 4]);
      if (nib > 9) nib = 9;
      v = v + nib * mult;
      mult = mult * 10;
    end
    return v;
  endfunction

  function automatic int max_val();
    int m;
    m = 1;
    for (int i = 0; i < N; i++) m = m * 10;
    return m - 1;
  endfunction

  task automatic model_reset();
    m_val = 0; m_psc = 0; m_idx = 0; m_div = 0; m_wrap = 0;
  endtask

  always @(negedge rst_n) begin
    model_reset();
    sb.delete();
  end

  always @(posedge clk) begin
    exp_t e;
    logic [W-1:0] b;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (m_div == SCAN_DIV - 1) begin
        m_div = 0;
        m_idx = (m_idx + 1) % N;
      end else begin
        m_div++;
      end
      m_wrap = 0;
      if (load) begin
        m_val = clamp_val(load_val);
        m_psc = 0;
      end else if (en) begin
        if (m_psc == PRESCALE - 1) begin
          m_psc = 0;
          if (up_dn) begin
            if (m_val == max_val()) begin m_val = 0; m_wrap = 1; end
            else m_val++;
          end else begin
            if (m_val == 0) begin m_val = max_val(); m_wrap = 1; end
            else m_val--;
          end
        end else begin
          m_psc++;
        end
      end
    end
    b     = to_bcd(m_val);
    e.cnt = b;
    e.sel = N'(1) << m_idx;
    e.dig = b[4*m_idx +: 4];
    e.wrp = m_wrap;
    sb.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_count", 32'(count), 32'(e.cnt));
      chk("sb_sel",   32'(digit_sel), 32'(e.sel));
      chk("sb_bcd",   32'(digit_bcd), 32'(e.dig));
      chk("sb_wrap",  32'(wrap), 32'(e.wrp));
    end
  end

  initial begin
    bit wrap_seen;
    logic [N-1:0] prev_sel;
    int changes;

    rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0;
    repeat (2) @(negedge clk);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_sel",   32'(digit_sel), 32'h1);
    chk("rst_bcd",   32'(digit_bcd), 32'h0);
    chk("rst_wrap",  32'(wrap), 32'h0);
    rst_n = 1'b1;

    // Count up 40 cycles -> ten steps.
    en = 1'b1; up_dn = 1'b1; wrap_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (wrap) wrap_seen = 1;
    end
    chk("up40_count", 32'(count), 32'h10);
    chk("up40_nowrap", 32'(wrap_seen), 32'h0);

    // Prescaler must hold its phase while disabled.
    repeat (2) @(negedge clk);
    en = 1'b0;
    repeat (10) @(negedge clk);
    chk("hold_count", 32'(count), 32'h10);
    en = 1'b1;
    @(negedge clk);
    chk("hold_resume_a", 32'(count), 32'h10);
    @(negedge clk);
    chk("hold_resume_b", 32'(count), 32'h11);

    // Load 98 then count up through the roll-over.
    en = 1'b0; load = 1'b1; load_val = 8'h98;
    @(negedge clk);
    chk("load98", 32'(count), 32'h98);
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    repeat (3) @(negedge clk);
    chk("up_pre_step", 32'(count), 32'h98);
    @(negedge clk);
    chk("up_99", 32'(count), 32'h99);
    repeat (4) @(negedge clk);
    chk("up_wrap_count", 32'(count), 32'h00);
    chk("up_wrap_pulse", 32'(wrap), 32'h1);
    @(negedge clk);
    chk("up_wrap_clear", 32'(wrap), 32'h0);

    // Load 00 then count down through the roll-under.
    en = 1'b0; load = 1'b1; load_val = 8'h00;
    @(negedge clk);
    load = 1'b0; en = 1'b1; up_dn = 1'b0;
    repeat (4) @(negedge clk);
    chk("dn_wrap_count", 32'(count), 32'h99);
    chk("dn_wrap_pulse", 32'(wrap), 32'h1);
    @(negedge clk);
    chk("dn_wrap_clear", 32'(wrap), 32'h0);
    repeat (3) @(negedge clk);
    chk("dn_98", 32'(count), 32'h98);

    // Out-of-range nibble is clamped on load.
    en = 1'b0; load = 1'b1; load_val = 8'hF3;
    @(negedge clk);
    chk("load_clamp", 32'(count), 32'h93);
    load = 1'b0;

    // Load on a step edge wins, and restarts the prescaler.
    en = 1'b1; up_dn = 1'b1;
    repeat (3) @(negedge clk);
    load = 1'b1; load_val = 8'h25;
    @(negedge clk);
    chk("load_on_step", 32'(count), 32'h25);
    load = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_load_hold", 32'(count), 32'h25);
    @(negedge clk);
    chk("post_load_step", 32'(count), 32'h26);

    // Scanner with count frozen at 47.
    en = 1'b0; load = 1'b1; load_val = 8'h47;
    @(negedge clk);
    load = 1'b0;
    prev_sel = digit_sel;
    changes = 0;
    repeat (8) begin
      @(negedge clk);
      chk("scan_onehot", 32'(digit_sel == 2'b01 || digit_sel == 2'b10), 32'h1);
      chk("scan_bcd", 32'(digit_bcd), (digit_sel == 2'b01) ? 32'h7 : 32'h4);
      if (digit_sel != prev_sel) changes++;
      prev_sel = digit_sel;
    end
    chk("scan_toggles", 32'(changes), 32'h4);

    // Asynchronous reset in the middle of counting.
    en = 1'b1; up_dn = 1'b1;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_count", 32'(count), 32'h0);
    chk("async_sel",   32'(digit_sel), 32'h1);
    chk("async_wrap",  32'(wrap), 32'h0);
    chk("async_bcd",   32'(digit_bcd), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rel_no_step", 32'(count), 32'h0);
    @(negedge clk);
    chk("rel_first_step", 32'(count), 32'h1);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_scan_counter.md
Name: bcd_scan_counter

Overview:
- Multi-digit BCD up/down counter with an internal step prescaler and a time-multiplexed digit scanner.
- Sits directly upstream of the team's BCD-to-7-segment decoder (DE1): presents one 4-bit BCD digit at a time on the decoder's W,X,Y,Z inputs.
- Also drives a one-hot digit select for the common-anode/cathode display enables.

Parameters:
- NUM_DIGITS, 2, number of BCD digits (1..8).
- PRESCALE, 4, clock cycles per count step (>=1); 1 means a step every enabled cycle.
- SCAN_DIV, 2, clock cycles each digit is shown before the scanner advances (>=1).

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  count enable; gates the prescaler.
- up_dn  in  1  1 = count up, 0 = count down; sampled on the step edge.
- load  in  1  synchronous parallel load strobe.
- load_val  in  4*NUM_DIGITS  load value; digit k = bits [4k+3:4k].
- count  out  4*NUM_DIGITS  current BCD value; digit 0 = least significant.
- digit_bcd  out  4  scanned digit to decoder; bit3=W, bit2=X, bit1=Y, bit0=Z.
- digit_sel  out  NUM_DIGITS  one-hot select of the scanned digit.
- wrap  out  1  one-cycle pulse on roll-over (all-9 to all-0 up, all-0 to all-9 down).

Behaviour:
- Reset (rst_n low, asynchronous, no clock needed):
  - count = 0, prescaler = 0, scan index = 0, scan divider = 0.
  - digit_sel = one-hot bit 0, digit_bcd = 0000, wrap = 0.
- Priority per edge: load > step > hold.
- Load:
  - count <= load_val, with each nibble > 9 clamped to 9.
  - Prescaler cleared; wrap = 0.
  - Scan index/divider unaffected.
- Prescaler:
  - Increments when en=1; holds when en=0.
  - At value PRESCALE-1 with en=1, that edge is a step edge and the prescaler returns to 0.
- Step up:
  - Digit 0 increments; a digit at 9 goes to 0 and carries into the next digit.
  - Ripple resolves in the same edge (combinational carry chain).
  - All digits 9 -> all 0 and wrap=1 for exactly the next cycle.
- Step down:
  - Digit 0 decrements; a digit at 0 goes to 9 and borrows.
  - All 0 -> all 9 and wrap=1.
- wrap is registered and cleared on every non-wrapping edge, so it is never high for two consecutive cycles.
- Scanner:
  - Free-running, independent of en and load.
  - Divider counts 0..SCAN_DIV-1; on reaching SCAN_DIV-1, scan index advances and wraps from NUM_DIGITS-1 to 0.
  - digit_sel = one-hot(index), registered.
  - digit_bcd = nibble[index] of count, combinational from registers, so a count change is visible on the same cycle the count register updates.
- Latency: count updates on the step edge; no added pipeline.
- Reset mid-operation: all state cleared immediately; first step occurs PRESCALE enabled cycles after rst_n deasserts.
- load and step on the same edge: load wins; the step is discarded.

Decomposition:
- Package bcd_pkg:
  - BCD_MAX = 4'd9, BCD_MIN = 4'd0.
  - bcd_t 4-bit nibble typedef.
  - bcd_clamp function (nibble > 9 -> 9).
- Sub-module bcd_digit: one nibble register with inc/dec, carry_in/borrow_in, carry_out/borrow_out and load/clamp. Instantiated NUM_DIGITS times via generate.
- Prescaler, scanner and wrap logic live in the top.

Test Plan (NUM_DIGITS=2, PRESCALE=4, SCAN_DIV=2):
- Reset then en=1, up_dn=1 for 40 clocks -> count=0x10, wrap never high; with en=0 for 10 clocks -> count frozen, prescaler holds.
- load_val=0x98, load pulse, then en=1 up -> 0x99 after 4 clocks, 0x00 after 8 clocks, wrap high exactly one cycle.
- load 0x00, en=1, up_dn=0 -> 0x99 after 4 clocks with one-cycle wrap; 0x98 after 8.
- load_val=0xF3 -> count=0x93; load asserted on a step edge -> loaded value kept, no increment.
- count=0x47 held (en=0) -> digit_sel toggles 01/10 every 2 clocks; digit_bcd 0111 with sel 01, 0100 with sel 10 (decoder shows 7=1110000, 4=0110011).
- rst_n pulsed low between clock edges during counting -> count=0x00, digit_sel=01, wrap=0 immediately; first step 4 clocks after release.
